// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: FSM state and stall-cause encodings.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LSTALL = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_LOAD   = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_HALT   = 2'd3
  } cause_e;

endpackage

// File: rtl/hazard_match.sv
// Single source/destination register comparator; register $0 never matches.
module hazard_match #(
  parameter int unsigned NB_REG_ADDR = 5
) (
  input  logic [NB_REG_ADDR-1:0] src_i,
  input  logic [NB_REG_ADDR-1:0] dst_i,
  input  logic                   use_i,
  output logic                   hit_o
);

  assign hit_o = use_i & (src_i == dst_i) & (dst_i != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: load-use / branch stalls, taken-branch flush, halt/drain sequence.
// Optional saturating performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NB_REG_ADDR     = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES    = 3,
  parameter int unsigned NB_PERF_CNT     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NB_REG_ADDR-1:0] i_id_rs,
  input  logic [NB_REG_ADDR-1:0] i_id_rt,
  input  logic                   i_id_use_rs,
  input  logic                   i_id_use_rt,
  input  logic                   i_id_is_branch,
  input  logic                   i_branch_taken,
  input  logic [NB_REG_ADDR-1:0] i_ex_rd,
  input  logic                   i_ex_reg_write,
  input  logic                   i_ex_mem_read,
  input  logic [NB_REG_ADDR-1:0] i_mem_rd,
  input  logic                   i_mem_mem_read,
  input  logic                   i_halt_req,
  input  logic                   i_resume,
  output logic                   o_stall,
  output logic                   o_bubble,
  output logic                   o_flush_if_id,
  output logic                   o_halted,
  output logic [1:0]             o_cause
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [NB_PERF_CNT-1:0] o_stall_cycles,
  output logic [NB_PERF_CNT-1:0] o_flush_count
`endif
);

  localparam logic [2:0] LuCntInit    = 3'(LOAD_USE_CYCLES - 2);
  localparam logic [2:0] DrainCntInit = 3'(DRAIN_CYCLES - 1);

  state_e     state_q;
  logic [2:0] cnt_q;

  logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic load_use, br_haz;
  logic stall;
  cause_e cause;

  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_rs_ex (
    .src_i(i_id_rs), .dst_i(i_ex_rd), .use_i(i_id_use_rs), .hit_o(rs_ex_hit)
  );
  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_rt_ex (
    .src_i(i_id_rt), .dst_i(i_ex_rd), .use_i(i_id_use_rt), .hit_o(rt_ex_hit)
  );
  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_rs_mem (
    .src_i(i_id_rs), .dst_i(i_mem_rd), .use_i(i_id_use_rs), .hit_o(rs_mem_hit)
  );
  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_rt_mem (
    .src_i(i_id_rt), .dst_i(i_mem_rd), .use_i(i_id_use_rt), .hit_o(rt_mem_hit)
  );

  // Raw detections; only acted on while the FSM is idle.
  assign load_use = i_ex_mem_read & (rs_ex_hit | rt_ex_hit);
  assign br_haz   = i_id_is_branch &
                    ((i_ex_reg_write & (rs_ex_hit | rt_ex_hit)) |
                     (i_mem_mem_read & (rs_mem_hit | rt_mem_hit)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_halt_req) begin
            state_q <= S_DRAIN;
            cnt_q   <= DrainCntInit;
          end else if (load_use && (LOAD_USE_CYCLES > 1)) begin
            state_q <= S_LSTALL;
            cnt_q   <= LuCntInit;
          end
        end
        S_LSTALL: begin
          if (cnt_q == 3'd0) state_q <= S_IDLE;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        S_DRAIN: begin
          if (cnt_q == 3'd0) state_q <= S_HALT;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        S_HALT: begin
          if (i_resume) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A halt request alone does not stall in S_IDLE; draining starts on the next edge.
  always_comb begin
    stall = 1'b0;
    cause = CAUSE_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (load_use) begin
          stall = 1'b1;
          cause = CAUSE_LOAD;
        end else if (br_haz) begin
          stall = 1'b1;
          cause = CAUSE_BRANCH;
        end
      end
      S_LSTALL: begin
        stall = 1'b1;
        cause = CAUSE_LOAD;
      end
      default: begin
        stall = 1'b1;
        cause = CAUSE_HALT;
      end
    endcase
    if (!i_rst_n) begin
      stall = 1'b0;
      cause = CAUSE_NONE;
    end
  end

  assign o_stall       = stall;
  assign o_bubble      = stall;
  assign o_cause       = cause;
  assign o_flush_if_id = i_rst_n & i_branch_taken & ~stall;
  assign o_halted      = i_rst_n & (state_q == S_HALT);

`ifdef HAZ_PERF_CNT_EN
  logic [NB_PERF_CNT-1:0] stall_cnt_q, stall_cnt_d;
  logic [NB_PERF_CNT-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stall && (stall_cnt_q != '1))       stall_cnt_d = stall_cnt_q + 1'b1;
    if (o_flush_if_id && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cycles = stall_cnt_q;
  assign o_flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit; three instances cover load-use depths 1, 3 and 4.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       use_rs, use_rt, is_branch, branch_taken;
  logic       ex_reg_write, ex_mem_read, mem_mem_read, halt_req, resume;

  logic       st1, bb1, fl1, hl1;
  logic [1:0] ca1;
  logic       st3, bb3, fl3, hl3;
  logic [1:0] ca3;
  logic       st4, bb4, fl4, hl4;
  logic [1:0] ca4;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3, sc4, fc4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.LOAD_USE_CYCLES(1), .DRAIN_CYCLES(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(use_rs), .i_id_use_rt(use_rt), .i_id_is_branch(is_branch),
    .i_branch_taken(branch_taken), .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write),
    .i_ex_mem_read(ex_mem_read), .i_mem_rd(mem_rd), .i_mem_mem_read(mem_mem_read),
    .i_halt_req(halt_req), .i_resume(resume), .o_stall(st1), .o_bubble(bb1),
    .o_flush_if_id(fl1), .o_halted(hl1), .o_cause(ca1)
`ifdef HAZ_PERF_CNT_EN
    , .o_stall_cycles(sc1), .o_flush_count(fc1)
`endif
  );

  hazard_ctrl_unit #(.LOAD_USE_CYCLES(3), .DRAIN_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(use_rs), .i_id_use_rt(use_rt), .i_id_is_branch(is_branch),
    .i_branch_taken(branch_taken), .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write),
    .i_ex_mem_read(ex_mem_read), .i_mem_rd(mem_rd), .i_mem_mem_read(mem_mem_read),
    .i_halt_req(halt_req), .i_resume(resume), .o_stall(st3), .o_bubble(bb3),
    .o_flush_if_id(fl3), .o_halted(hl3), .o_cause(ca3)
`ifdef HAZ_PERF_CNT_EN
    , .o_stall_cycles(sc3), .o_flush_count(fc3)
`endif
  );

  hazard_ctrl_unit #(.LOAD_USE_CYCLES(4), .DRAIN_CYCLES(3)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(use_rs), .i_id_use_rt(use_rt), .i_id_is_branch(is_branch),
    .i_branch_taken(branch_taken), .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write),
    .i_ex_mem_read(ex_mem_read), .i_mem_rd(mem_rd), .i_mem_mem_read(mem_mem_read),
    .i_halt_req(halt_req), .i_resume(resume), .o_stall(st4), .o_bubble(bb4),
    .o_flush_if_id(fl4), .o_halted(hl4), .o_cause(ca4)
`ifdef HAZ_PERF_CNT_EN
    , .o_stall_cycles(sc4), .o_flush_count(fc4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    use_rs = 1'b0; use_rt = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_mem_read = 1'b0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; use_rs = 1'b1;
  endtask

  initial begin
    clear_inputs();
    // Reset with a live load-use and taken branch: every output forced low.
    rst_n = 1'b0;
    set_load_use();
    branch_taken = 1'b1;
    tick();
    tick();
    chk("rst_stall", 32'(st1), 32'd0);
    chk("rst_bubble", 32'(bb1), 32'd0);
    chk("rst_cause", 32'(ca1), 32'd0);
    chk("rst_flush", 32'(fl1), 32'd0);
    chk("rst_halted", 32'(hl1), 32'd0);

    // Load-use with simultaneous taken branch: stall wins.
    rst_n = 1'b1;
    #1;
    chk("lu1_stall", 32'(st1), 32'd1);
    chk("lu1_bubble", 32'(bb1), 32'd1);
    chk("lu1_cause", 32'(ca1), 32'd1);
    chk("lu1_noflush", 32'(fl1), 32'd0);
    chk("lu3_c1_stall", 32'(st3), 32'd1);
    tick();
    clear_inputs();
    #1;
    chk("lu1_released", 32'(st1), 32'd0);
    chk("lu1_cause_clr", 32'(ca1), 32'd0);
    chk("lu3_c2_stall", 32'(st3), 32'd1);
    chk("lu3_c2_cause", 32'(ca3), 32'd1);
    tick();
    chk("lu3_c3_stall", 32'(st3), 32'd1);
    chk("lu4_c3_stall", 32'(st4), 32'd1);
    tick();
    chk("lu3_done", 32'(st3), 32'd0);
    chk("lu4_c4_stall", 32'(st4), 32'd1);
    tick();
    chk("lu4_done", 32'(st4), 32'd0);

    // Register $0 and unused sources never hazard.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; use_rs = 1'b1;
    #1;
    chk("r0_nostall", 32'(st1), 32'd0);
    ex_rd = 5'd8; id_rs = 5'd8; use_rs = 1'b0;
    #1;
    chk("unused_nostall", 32'(st1), 32'd0);
    id_rt = 5'd8; use_rt = 1'b1;
    #1;
    chk("rt_lu_stall", 32'(st1), 32'd1);
    clear_inputs();
    tick();

    // Branch hazard against EX, then taken with no hazard -> flush.
    is_branch = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; use_rt = 1'b1;
    branch_taken = 1'b1;
    #1;
    chk("br_ex_stall", 32'(st1), 32'd1);
    chk("br_ex_cause", 32'(ca1), 32'd2);
    chk("br_ex_noflush", 32'(fl1), 32'd0);
    tick();
    ex_rd = 5'd0;
    #1;
    chk("br_taken_nostall", 32'(st1), 32'd0);
    chk("br_taken_flush", 32'(fl1), 32'd1);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("br_flush_clr", 32'(fl1), 32'd0);
    // MEM-stage load feeding a branch; a non-load in MEM does not.
    clear_inputs();
    is_branch = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd7; id_rs = 5'd7; use_rs = 1'b1;
    #1;
    chk("br_mem_stall", 32'(st1), 32'd1);
    chk("br_mem_cause", 32'(ca1), 32'd2);
    mem_mem_read = 1'b0;
    #1;
    chk("br_mem_nonload", 32'(st1), 32'd0);
    clear_inputs();
    tick();

    // Halt: request alone does not stall in idle, then 3 drain cycles, then halted.
    halt_req = 1'b1;
    #1;
    chk("halt_req_idle", 32'(st1), 32'd0);
    tick();
    chk("drain1_stall", 32'(st1), 32'd1);
    chk("drain1_bubble", 32'(bb1), 32'd1);
    chk("drain1_cause", 32'(ca1), 32'd3);
    chk("drain1_halted", 32'(hl1), 32'd0);
    tick();
    chk("drain2_stall", 32'(st1), 32'd1);
    tick();
    chk("drain3_stall", 32'(st1), 32'd1);
    chk("drain3_halted", 32'(hl1), 32'd0);
    tick();
    chk("halted", 32'(hl1), 32'd1);
    chk("halted_stall", 32'(st1), 32'd1);
    chk("halted_cause", 32'(ca1), 32'd3);
    tick();
    chk("halted_held", 32'(hl1), 32'd1);
    halt_req = 1'b0;
    resume = 1'b1;
    #1;
    chk("resume_same_cycle", 32'(hl1), 32'd1);
    tick();
    resume = 1'b0;
    #1;
    chk("resumed_halted", 32'(hl1), 32'd0);
    chk("resumed_stall", 32'(st1), 32'd0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    chk("resume_idle_noeffect", 32'(st1), 32'd0);

    // Reset on the 2nd stall cycle of a 4-cycle load-use.
    set_load_use();
    #1;
    chk("lu4_r_c1", 32'(st4), 32'd1);
    tick();
    clear_inputs();
    #1;
    chk("lu4_r_c2", 32'(st4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(st4), 32'd0);
    chk("midrst_bubble", 32'(bb4), 32'd0);
    chk("midrst_cause", 32'(ca4), 32'd0);
    chk("midrst_halted", 32'(hl4), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("postrst_idle", 32'(st4), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("postrst_stall_cnt", sc4, 32'd0);
    chk("postrst_flush_cnt", fc1, 32'd0);
`endif
    tick();
    chk("postrst_idle2", 32'(st4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
